// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the PC, addresses the combinational instruction ROM and
// loads the IF/ID register, with stall, EX redirect, early jump and halt/resume.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          EARLY_JUMP = 1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] Addr,
    input  logic [31:0] INST,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        halt_req,
    input  logic        resume,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        halted,
    output logic [31:0] fetch_count
);

    typedef enum logic {RUN, HALTED} state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

    localparam logic [5:0] OP_J = 6'b000010;

    state_t      state;
    if_id_t      if_id;
    logic [31:0] pc;
    logic [31:0] fcnt;
    logic        halted_q;

    logic [31:0] pc_plus4;
    logic [31:0] br_pc;
    logic [31:0] seq_pc;
    logic        is_jump;
    logic        unused_ok;

    assign pc_plus4  = pc + 32'd4;
    assign br_pc     = {br_target[31:2], 2'b00};
    assign is_jump   = (EARLY_JUMP != 0) && (INST[31:26] == OP_J);
    // Jump target keeps the region bits of the delay-slot address.
    assign seq_pc    = is_jump ? {pc_plus4[31:28], INST[25:0], 2'b00} : pc_plus4;
    assign unused_ok = ^{br_target[1:0], pc[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            pc       <= {RESET_PC[31:2], 2'b00};
            if_id    <= '0;
            fcnt     <= '0;
            halted_q <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (br_taken) begin
                        // Redirect wins over stall and halt; IF/ID pc fields hold.
                        pc          <= br_pc;
                        if_id.inst  <= '0;
                        if_id.valid <= 1'b0;
                    end else if (halt_req) begin
                        state       <= HALTED;
                        halted_q    <= 1'b1;
                        if_id.inst  <= '0;
                        if_id.valid <= 1'b0;
                    end else if (!stall) begin
                        if_id.inst     <= INST;
                        if_id.pc       <= pc;
                        if_id.pc_plus4 <= pc_plus4;
                        if_id.valid    <= 1'b1;
                        fcnt           <= fcnt + 32'd1;
                        pc             <= seq_pc;
                    end
                end
                HALTED: begin
                    if_id.inst  <= '0;
                    if_id.valid <= 1'b0;
                    if (br_taken) pc <= br_pc;
                    if (resume) begin
                        state    <= RUN;
                        halted_q <= 1'b0;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign Addr           = {pc[31:2], 2'b00};
    assign if_id_inst     = if_id.inst;
    assign if_id_pc       = if_id.pc;
    assign if_id_pc_plus4 = if_id.pc_plus4;
    assign if_id_valid    = if_id.valid;
    assign halted         = halted_q;
    assign fetch_count    = fcnt;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench: two fetch units (early jump on/off) share one ROM image and controls.
module tb_inst_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall, br_taken, halt_req, resume;
    logic [31:0] br_target;
    logic [31:0] rom [0:63];

    logic [31:0] addr_a, inst_a, ii_a, ipc_a, ip4_a, fc_a;
    logic        iv_a, h_a;
    logic [31:0] addr_b, inst_b, ii_b, ipc_b, ip4_b, fc_b;
    logic        iv_b, h_b;

    assign inst_a = rom[addr_a[7:2]];
    assign inst_b = rom[addr_b[7:2]];

    inst_fetch_unit #(.RESET_PC(32'h0), .EARLY_JUMP(1)) dut_a (
        .clk(clk), .rst(rst), .Addr(addr_a), .INST(inst_a), .stall(stall),
        .br_taken(br_taken), .br_target(br_target), .halt_req(halt_req), .resume(resume),
        .if_id_inst(ii_a), .if_id_pc(ipc_a), .if_id_pc_plus4(ip4_a), .if_id_valid(iv_a),
        .halted(h_a), .fetch_count(fc_a));

    inst_fetch_unit #(.RESET_PC(32'h0), .EARLY_JUMP(0)) dut_b (
        .clk(clk), .rst(rst), .Addr(addr_b), .INST(inst_b), .stall(stall),
        .br_taken(br_taken), .br_target(br_target), .halt_req(halt_req), .resume(resume),
        .if_id_inst(ii_b), .if_id_pc(ipc_b), .if_id_pc_plus4(ip4_b), .if_id_valid(iv_b),
        .halted(h_b), .fetch_count(fc_b));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full IF/ID + status snapshot of the early-jump unit.
    task automatic chk_a(input string tag, input logic [31:0] addr, input logic [31:0] inst,
                         input logic [31:0] pc, input logic valid, input logic hlt,
                         input logic [31:0] fc);
        chk({tag, ".addr"},  addr_a, addr);
        chk({tag, ".inst"},  ii_a, inst);
        chk({tag, ".pc"},    ipc_a, pc);
        chk({tag, ".valid"}, {31'd0, iv_a}, {31'd0, valid});
        chk({tag, ".halt"},  {31'd0, h_a}, {31'd0, hlt});
        chk({tag, ".fc"},    fc_a, fc);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 32'h0;
        rom[1] = 32'h2421_0004;
        rom[6] = 32'h0800_0008;
        rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = 32'h0;
        halt_req = 1'b0; resume = 1'b0;

        step();
        chk_a("rst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("rst.pc4", ip4_a, 32'h0);
        chk("rst.b_addr", addr_b, 32'h0);
        rst = 1'b0;

        // Free run 0x00..0x18; word 6 is the j to 0x20.
        for (int i = 0; i < 7; i++) begin
            chk("run.addr_pre", addr_a, 32'(4 * i));
            step();
            chk("run.pc", ipc_a, 32'(4 * i));
            chk("run.pc4", ip4_a, 32'(4 * i + 4));
            chk("run.inst", ii_a, rom[i]);
            chk("run.valid", {31'd0, iv_a}, 32'd1);
        end
        chk("jmp.addr_early", addr_a, 32'h20);
        chk("jmp.addr_late", addr_b, 32'h1C);
        chk("jmp.inst_b", ii_b, 32'h0800_0008);
        chk("jmp.valid_b", {31'd0, iv_b}, 32'd1);
        chk("run.fc", fc_a, 32'd7);
        chk("run.fc_b", fc_b, 32'd7);

        // Redirect to 0x08 (bubble, pc fields hold), then fetch to 0x0C.
        br_taken = 1'b1; br_target = 32'h08;
        step();
        chk_a("redir", 32'h08, 32'h0, 32'h18, 1'b0, 1'b0, 32'd7);
        chk("redir.b_addr", addr_b, 32'h08);
        br_taken = 1'b0;
        step();
        chk_a("post_redir", 32'h0C, 32'h0, 32'h08, 1'b1, 1'b0, 32'd8);

        // Stall 3 cycles at 0x0C.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_a("stall", 32'h0C, 32'h0, 32'h08, 1'b1, 1'b0, 32'd8);
        end
        stall = 1'b0;
        step();
        chk_a("unstall", 32'h10, 32'h0, 32'h0C, 1'b1, 1'b0, 32'd9);

        // Halt pulse at 0x10, held for 5 cycles, then resume.
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        chk_a("halt0", 32'h10, 32'h0, 32'h0C, 1'b0, 1'b1, 32'd9);
        for (int i = 0; i < 4; i++) begin
            step();
            chk_a("halt", 32'h10, 32'h0, 32'h0C, 1'b0, 1'b1, 32'd9);
        end
        resume = 1'b1;
        step();
        resume = 1'b0;
        chk_a("resume", 32'h10, 32'h0, 32'h0C, 1'b0, 1'b0, 32'd9);
        step();
        chk_a("resume1", 32'h14, 32'h0, 32'h10, 1'b1, 1'b0, 32'd10);

        // Redirect with stall in the same cycle; misaligned target aligned down.
        br_taken = 1'b1; br_target = 32'h42; stall = 1'b1;
        step();
        chk_a("brstall", 32'h40, 32'h0, 32'h10, 1'b0, 1'b0, 32'd10);
        br_taken = 1'b0; stall = 1'b0;
        step();
        chk_a("brstall1", 32'h44, 32'h0, 32'h40, 1'b1, 1'b0, 32'd11);

        // PC wrap at the top of the address space.
        br_taken = 1'b1; br_target = 32'hFFFF_FFFC;
        step();
        br_taken = 1'b0;
        chk("wrap.addr_pre", addr_a, 32'hFFFF_FFFC);
        step();
        chk_a("wrap", 32'h0, 32'h0, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'd12);
        chk("wrap.pc4", ip4_a, 32'h0);

        // Redirect beats halt_req in the same cycle.
        br_taken = 1'b1; br_target = 32'h80; halt_req = 1'b1;
        step();
        br_taken = 1'b0; halt_req = 1'b0;
        chk_a("brhalt", 32'h80, 32'h0, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'd12);
        step();
        chk("brhalt.run", ipc_a, 32'h80);

        // Mid-run reset clears everything.
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_a("rst2", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("rst2.pc4", ip4_a, 32'h0);
        chk("rst2.b_fc", fc_b, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Fetch-side initiator for the combinational instruction ROM: owns the PC, drives the ROM address, and captures the returned instruction into the IF/ID pipeline register.
- Computes the next PC from sequential increment, fetch-stage jump resolution, and branch redirects from EX.
- Supports stall, flush and halt/resume control.
- Sits between the ROM and the decode stage of the CPU.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- EARLY_JUMP, 1, 1 = resolve `j` (opcode 6'b000010) in fetch; 0 = fetch `j` like any other instruction (PC+4).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- Addr  output  32  ROM address; combinationally equal to pc.
- INST  input  32  ROM data for Addr, valid in the same cycle.
- stall  input  1  hold PC and IF/ID contents.
- br_taken  input  1  EX-stage redirect request.
- br_target  input  32  redirect target.
- halt_req  input  1  enter HALTED.
- resume  input  1  leave HALTED.
- if_id_inst  output  32  registered instruction.
- if_id_pc  output  32  PC of if_id_inst.
- if_id_pc_plus4  output  32  if_id_pc + 4.
- if_id_valid  output  1  IF/ID holds a real instruction.
- halted  output  1  FSM is in HALTED.
- fetch_count  output  32  count of instructions loaded into IF/ID with valid=1.

Behaviour:
- Reset, applied at the clock edge while rst=1:
  - pc=RESET_PC, state=RUN.
  - if_id_inst=0, if_id_pc=0, if_id_pc_plus4=0, if_id_valid=0.
  - halted=0, fetch_count=0.
  - rst mid-operation discards everything at the next edge; rst has top priority.
- Addr = {pc[31:2],2'b00}, combinational. pc[1:0] is always 0.
- FSM has two states, RUN and HALTED:
  - RUN→HALTED when halt_req=1 and br_taken=0.
  - HALTED→RUN when resume=1.
  - halt_req and resume both high in RUN: go to HALTED.
  - halt_req and resume both high in HALTED: go to RUN.
- Per-edge priority in RUN:
  1. br_taken=1:
     - pc<={br_target[31:2],2'b00}.
     - if_id_inst<=0, if_id_valid<=0 (flush); if_id_pc and if_id_pc_plus4 hold.
     - Overrides stall and halt_req that cycle.
  2. stall=1: pc and all IF/ID outputs hold; fetch_count holds.
  3. Otherwise:
     - if_id_inst<=INST, if_id_pc<=pc, if_id_pc_plus4<=pc+4, if_id_valid<=1.
     - fetch_count<=fetch_count+1 (32-bit wrap).
     - Next PC: if EARLY_JUMP=1 and INST[31:26]==6'b000010, pc<={pc_plus4[31:28],INST[25:0],2'b00}; else pc<=pc+4.
     - The jump instruction itself still enters IF/ID with valid=1.
- In HALTED:
  - pc holds, if_id_valid<=0, if_id_inst<=0, fetch_count holds, halted=1.
  - br_taken in HALTED still updates pc (no state change), so a redirect is not lost.
- Fetch latency: an instruction at PC p appears on if_id_inst one edge after Addr=p.
- Redirect penalty is one bubble. An early jump costs no bubble.
- PC arithmetic is modulo 2^32: pc=32'hFFFFFFFC increments to 0.
- br_target with nonzero [1:0] is silently aligned down.
- A ROM word of 0 (nop) is fetched normally with valid=1.

Test Plan:
- Reset, then 7 free-running edges with ROM word 1 = addiu (0x24210004) and others nop:
  - Addr sequence 0x00,0x04,…,0x18.
  - if_id_pc trails Addr by one cycle; if_id_valid=0 for the first cycle after reset.
  - fetch_count=7.
- Word at 0x18 = 0x08000008 (j), EARLY_JUMP=1:
  - Edge after Addr=0x18 gives Addr=0x20, if_id_inst=0x08000008, if_id_valid=1.
  - With EARLY_JUMP=0, the same case gives Addr=0x1C.
- Stall held 3 cycles at Addr=0x0C: Addr, if_id_*, fetch_count all constant; the edge after release gives Addr=0x10.
- br_taken=1, br_target=0x00000042, stall=1 in the same cycle:
  - Next Addr=0x40, if_id_valid=0, if_id_inst=0.
  - The following edge gives if_id_pc=0x40, valid=1.
- halt_req pulse at Addr=0x10:
  - halted=1, Addr stays 0x10, valid=0 for 5 cycles.
  - resume: halted=0; the next edge gives if_id_pc=0x10, Addr=0x14.
- Force pc to 0xFFFFFFFC via br_target, run one edge → Addr=0x00. rst asserted mid-run → next edge Addr=RESET_PC, all outputs 0.
